// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE-array job scheduler: FSM state encodings
// and an index-width helper used to size requester and slot fields.
package pe_sched_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT_UP = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at
// or after ptr, wrapping modulo N. Output is one-hot plus its index.
module rr_arbiter
    import pe_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan candidates starting at ptr; the first asserted one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/pe_job_scheduler.sv
// Shares one PE-array controller among NUM_REQ requesters. Arbitrates jobs
// round-robin, pulses array_start with the job's slot, watches the array
// through completion with a watchdog and returns a done/timeout response.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. req_ready is combinational, one-hot and only asserted in
// IDLE while the array is idle; done_valid/done_id/done_timeout stay stable
// until done_ready is seen high.
module pe_job_scheduler
    import pe_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SLOT_NUM       = 4,
    parameter int SLOT_W         = idx_width(SLOT_NUM),
    parameter int ID_W           = idx_width(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*SLOT_W-1:0]  req_slot,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       array_start,
    output logic [SLOT_W-1:0]          array_slot,
    input  logic                       array_busy,
    output logic                       done_valid,
    output logic [ID_W-1:0]            done_id,
    output logic                       done_timeout,
    input  logic                       done_ready,
    output logic                       sched_busy,
    output logic [STATE_W-1:0]         dbg_state
);

    localparam int              WD_W    = idx_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               grant_en;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // A grant is only possible from IDLE while the array is quiet.
    always_comb begin
        grant_en  = (state_q == S_IDLE) && !array_busy && (|req_valid);
        req_ready = grant_en ? arb_gnt : '0;
    end

    // Next-state, latch and watchdog logic.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        slot_d    = slot_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    id_d     = arb_idx;
                    slot_d   = req_slot[int'(arb_idx)*SLOT_W +: SLOT_W];
                    rr_ptr_d = (arb_idx == ID_LAST) ? '0 : arb_idx + ID_W'(1);
                    state_d  = S_START;
                end
            end
            S_START: begin
                wd_cnt_d  = '0;
                timeout_d = 1'b0;
                state_d   = S_WAIT_UP;
            end
            S_WAIT_UP: begin
                // No completion is possible before busy rises, so expiry
                // takes precedence here even if busy rises this cycle.
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (wd_cnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else if (array_busy) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Completion beats a simultaneous watchdog expiry.
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (!array_busy) begin
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-job drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            slot_q    <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            slot_q    <= slot_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        array_start  = (state_q == S_START);
        array_slot   = slot_q;
        done_valid   = (state_q == S_RESP);
        done_id      = id_q;
        done_timeout = timeout_q;
        sched_busy   = (state_q != S_IDLE);
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Self-checking bench for pe_job_scheduler: directed scenarios with a
// behavioural array model and a response scoreboard.
module tb_pe_job_scheduler;
    import pe_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int SLOT_W  = 2;
    localparam int ID_W    = 2;
    localparam int EW      = ID_W + 1 + SLOT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*SLOT_W-1:0] req_slot  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      array_start;
    logic [SLOT_W-1:0]         array_slot;
    logic                      array_busy = 1'b0;
    logic                      done_valid;
    logic [ID_W-1:0]           done_id;
    logic                      done_timeout;
    logic                      done_ready = 1'b1;
    logic                      sched_busy;
    logic [STATE_W-1:0]        dbg_state;

    pe_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .SLOT_NUM       (4),
        .SLOT_W         (SLOT_W),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_ready    (req_ready),
        .array_start  (array_start),
        .array_slot   (array_slot),
        .array_busy   (array_busy),
        .done_valid   (done_valid),
        .done_id      (done_id),
        .done_timeout (done_timeout),
        .done_ready   (done_ready),
        .sched_busy   (sched_busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    logic [SLOT_W-1:0] slots [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Response scoreboard: samples late in the cycle, after drivers settle.
    always begin
        @(negedge clk);
        #3;
        if (!reset && done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_e = exp_q.pop_front();
                check("resp", 32'({done_id, done_timeout, array_slot}), 32'(exp_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(req_ready != '0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sched_busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(sched_busy), 32'd0);
    endtask

    // Array controller model: busy rises `up` cycles after start, lasts `len`.
    task automatic run_array(input int up, input int len);
        tick();
        check("start_one_cycle", 32'(array_start), 32'd0);
        repeat (up - 1) tick();
        array_busy = 1'b1;
        repeat (len) tick();
        array_busy = 1'b0;
    endtask

    task automatic set_slots();
        for (int i = 0; i < NUM_REQ; i++) req_slot[i*SLOT_W +: SLOT_W] = slots[i];
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int e;
        tick();
        tick();
        check("reset_outputs",
              32'({req_ready, array_start, array_slot, done_valid, done_id, done_timeout, sched_busy, dbg_state}),
              32'd0);
        reset = 1'b0;
        tick();

        // Single job from requester 2, slot 2.
        slots[0] = 2'd0; slots[1] = 2'd0; slots[2] = 2'd2; slots[3] = 2'd0;
        set_slots();
        req_valid = 4'b0100;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h4);
        exp_q.push_back({2'd2, 1'b0, 2'd2});
        tick();
        req_valid = '0;
        check("t1_start", 32'(array_start), 32'd1);
        check("t1_slot", 32'(array_slot), 32'd2);
        run_array(2, 20);
        wait_idle("t1_idle");

        // Round robin from a fresh pointer with everybody requesting.
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) slots[i] = SLOT_W'($urandom_range(0, 3));
        set_slots();
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            e = j % NUM_REQ;
            wait_ready("t2_ready_seen");
            check("t2_grant_order", 32'(req_ready), 32'd1 << e);
            exp_q.push_back({ID_W'(e), 1'b0, slots[e]});
            tick();
            check("t2_start", 32'(array_start), 32'd1);
            check("t2_slot", 32'(array_slot), 32'(slots[e]));
            run_array($urandom_range(1, 3), $urandom_range(2, 10));
            wait_idle("t2_idle");
        end
        req_valid = '0;

        // Watchdog expiry with response backpressure (pointer now at 1).
        done_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("t3_req_ready", 32'(req_ready), 32'h1);
        exp_q.push_back({2'd0, 1'b1, slots[0]});
        tick();
        req_valid = '0;
        check("t3_start", 32'(array_start), 32'd1);
        cnt = 0;
        while (!done_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        check("t3_latency", 32'(cnt), 32'd65);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_hold",
                  32'({done_valid, done_id, done_timeout, array_slot, req_ready}),
                  32'({1'b1, 2'd0, 1'b1, slots[0], 4'b0000}));
        end
        req_valid = '0;
        done_ready = 1'b1;
        tick();
        check("t4_released", 32'({sched_busy, done_valid}), 32'd0);

        // Foreign array activity in IDLE blocks all grants.
        array_busy = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_blocked", 32'({req_ready, sched_busy}), 32'd0);
        end
        array_busy = 1'b0;
        #1;
        check("t5_unblocked", 32'(req_ready), 32'h1);
        exp_q.push_back({2'd0, 1'b0, slots[0]});
        tick();
        req_valid = '0;
        check("t5_start", 32'(array_start), 32'd1);
        run_array(1, 4);
        wait_idle("t5_idle");

        // Reset in the middle of RUN drops the job (pointer now at 1).
        req_valid = 4'b0010;
        #1;
        check("t6_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("t6_start", 32'(array_start), 32'd1);
        tick();
        tick();
        array_busy = 1'b1;
        repeat (3) tick();
        check("t6_in_run", 32'(dbg_state), 32'(S_RUN));
        reset = 1'b1;
        array_busy = 1'b0;
        tick();
        check("t6_reset_outputs",
              32'({req_ready, array_start, array_slot, done_valid, done_id, done_timeout, sched_busy, dbg_state}),
              32'd0);
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("t6_ptr_cleared", 32'(req_ready), 32'h1);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_no_resp", 32'(done_valid), 32'd0);
        end

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
